// File: rtl/axis_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_arb_pkg                                                         |
// | Shared types and constants for the packet-aware AXIS arbiter.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BEATS  = 16;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick2                                                             |
// | Combinational two-way round-robin picker, one-hot result.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick2
    import axis_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] pick
);

    // A lone request wins outright; on a tie the source that did not go last wins.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last_grant ? GNT_0 : GNT_1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_pkt_arbiter                                                     |
// | Packet-hold round-robin arbiter for two AXIS sources with watchdog.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BEATS  = DEF_MAX_BEATS
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [DATA_WIDTH-1:0] DATA_in_0,
    input  logic                  TVALID_in_0,
    input  logic                  TLAST_in_0,
    output logic                  TREADY_in_0,
    input  logic [DATA_WIDTH-1:0] DATA_in_1,
    input  logic                  TVALID_in_1,
    input  logic                  TLAST_in_1,
    output logic                  TREADY_in_1,
    output logic [DATA_WIDTH-1:0] DATA_out,
    output logic                  TVALID_out,
    output logic                  TLAST_out,
    input  logic                  TREADY_out,
    output logic [1:0]            grant,
    output logic                  trunc
);

    localparam int               CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_BEATS - 1);

    arb_state_t       r_state;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [1:0]       r_grant;
    logic             r_trunc;

    logic [1:0]       w_pick;
    logic             w_src_last;
    logic             w_xfer;

    rr_pick2 u_pick (
        .req        ({TVALID_in_1, TVALID_in_0}),
        .last_grant (r_last_grant),
        .pick       (w_pick)
    );

    // Pure pass-through of the owning source; idle drives everything low.
    always_comb begin
        DATA_out    = '0;
        TVALID_out  = 1'b0;
        TREADY_in_0 = 1'b0;
        TREADY_in_1 = 1'b0;
        w_src_last  = 1'b0;
        case (r_state)
            BUSY0: begin
                DATA_out    = DATA_in_0;
                TVALID_out  = TVALID_in_0;
                w_src_last  = TLAST_in_0;
                TREADY_in_0 = TREADY_out;
            end
            BUSY1: begin
                DATA_out    = DATA_in_1;
                TVALID_out  = TVALID_in_1;
                w_src_last  = TLAST_in_1;
                TREADY_in_1 = TREADY_out;
            end
            default: ;
        endcase
        TLAST_out = w_src_last | ((r_state != IDLE) && (r_beat_cnt == WD_LAST));
    end

    assign w_xfer = TVALID_out & TREADY_out;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_beat_cnt   <= '0;
            r_grant      <= GNT_NONE;
            r_trunc      <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick == GNT_0) begin
                        r_state <= BUSY0;
                        r_grant <= GNT_0;
                    end else if (w_pick == GNT_1) begin
                        r_state <= BUSY1;
                        r_grant <= GNT_1;
                    end
                end
                BUSY0, BUSY1: begin
                    if (w_xfer) begin
                        if (TLAST_out) begin
                            // A forced end leaves the source mid-packet; flag it.
                            r_state      <= IDLE;
                            r_grant      <= GNT_NONE;
                            r_beat_cnt   <= '0;
                            r_last_grant <= (r_state == BUSY1);
                            r_trunc      <= ~w_src_last;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= GNT_NONE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign trunc = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_pkt_arbiter                                                  |
// | Self-checking bench: directed scenarios plus randomized traffic.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_axis_pkt_arbiter;
    import axis_arb_pkg::*;

    localparam int DW = 8;
    localparam int MB = 16;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [DW-1:0] DATA_in_0 = '0, DATA_in_1 = '0, DATA_out;
    logic          TVALID_in_0 = 1'b0, TLAST_in_0 = 1'b0, TREADY_in_0;
    logic          TVALID_in_1 = 1'b0, TLAST_in_1 = 1'b0, TREADY_in_1;
    logic          TVALID_out, TLAST_out;
    logic          TREADY_out = 1'b0;
    logic [1:0]    grant;
    logic          trunc;

    always #5 ACLK = ~ACLK;

    axis_pkt_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .DATA_in_0(DATA_in_0), .TVALID_in_0(TVALID_in_0), .TLAST_in_0(TLAST_in_0), .TREADY_in_0(TREADY_in_0),
        .DATA_in_1(DATA_in_1), .TVALID_in_1(TVALID_in_1), .TLAST_in_1(TLAST_in_1), .TREADY_in_1(TREADY_in_1),
        .DATA_out(DATA_out), .TVALID_out(TVALID_out), .TLAST_out(TLAST_out), .TREADY_out(TREADY_out),
        .grant(grant), .trunc(trunc)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Source generators: per-source packet length, beat index, next byte.
    int         len[2], idx[2], vpct[2], fixlen[2];
    logic [7:0] nxt[2], d[2];
    bit         v[2], l[2], p_hs[2];
    int         rpct;

    // Reference model: owner index (-1 = none), beats taken, last owner.
    int owner, cnt, lastg;
    bit mtrunc;

    // Logs of output beats and per-cycle registered outputs.
    logic [7:0] ob_data[$];
    bit         ob_last[$];
    int         ob_cyc[$];
    logic [1:0] ob_gnt[$];
    logic [1:0] g_log[$];
    bit         t_log[$];
    int         cyc;

    function automatic void new_pkt(input int s);
        len[s] = (fixlen[s] > 0) ? fixlen[s] : int'($urandom_range(1, 40));
        idx[s] = 0;
    endfunction

    function automatic void drive_src(input int s, input bit hs);
        if (hs) begin
            nxt[s] = nxt[s] + 8'd1;
            idx[s]++;
            if (idx[s] == len[s]) new_pkt(s);
            v[s] = 1'b0;
        end
        if (!v[s]) v[s] = (int'($urandom_range(1, 100)) <= vpct[s]);
        d[s] = nxt[s];
        l[s] = (idx[s] == len[s] - 1);
    endfunction

    task automatic apply_ports();
        DATA_in_0 = d[0]; TVALID_in_0 = v[0]; TLAST_in_0 = l[0];
        DATA_in_1 = d[1]; TVALID_in_1 = v[1]; TLAST_in_1 = l[1];
    endtask

    task automatic model_reset();
        owner = -1; cnt = 0; lastg = 1; mtrunc = 1'b0;
        p_hs[0] = 1'b0; p_hs[1] = 1'b0;
    endtask

    task automatic clear_logs();
        ob_data.delete(); ob_last.delete(); ob_cyc.delete(); ob_gnt.delete();
        g_log.delete(); t_log.delete(); cyc = 0;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        for (int s = 0; s < 2; s++) begin
            v[s] = 1'b0; vpct[s] = 0; fixlen[s] = 0;
            new_pkt(s); l[s] = 1'b0;
        end
        nxt[0] = 8'h10; nxt[1] = 8'h80; d[0] = 8'h10; d[1] = 8'h80;
        apply_ports();
        TREADY_out = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        model_reset();
        clear_logs();
    endtask

    task automatic step();
        logic [7:0] ed;
        bit ev, el, er0, er1, srcl;
        @(negedge ACLK);
        drive_src(0, p_hs[0]);
        drive_src(1, p_hs[1]);
        apply_ports();
        TREADY_out = (int'($urandom_range(1, 100)) <= rpct);
        #1;
        ed = 8'h00; ev = 1'b0; el = 1'b0; er0 = 1'b0; er1 = 1'b0; srcl = 1'b0;
        if (owner >= 0) begin
            ed   = d[owner];
            ev   = v[owner];
            srcl = l[owner];
            el   = srcl || (cnt == MB - 1);
            if (owner == 0) er0 = TREADY_out; else er1 = TREADY_out;
        end
        check_val("data_out",  DATA_out, ed);
        check_val("tvalid",    TVALID_out, ev);
        check_val("tlast",     TLAST_out, el);
        check_val("tready0",   TREADY_in_0, er0);
        check_val("tready1",   TREADY_in_1, er1);
        check_val("grant",     grant, (owner < 0) ? 32'd0 : 32'(1 << owner));
        check_val("trunc",     trunc, mtrunc);
        g_log.push_back(grant);
        t_log.push_back(trunc);
        if (ev && TREADY_out) begin
            ob_data.push_back(DATA_out);
            ob_last.push_back(TLAST_out);
            ob_cyc.push_back(cyc);
            ob_gnt.push_back(grant);
        end
        p_hs[0] = v[0] && er0;
        p_hs[1] = v[1] && er1;
        mtrunc = 1'b0;
        if (owner < 0) begin
            if (v[0] && v[1])  owner = (lastg == 1) ? 0 : 1;
            else if (v[0])     owner = 0;
            else if (v[1])     owner = 1;
        end else if (ev && TREADY_out) begin
            if (el) begin
                mtrunc = !srcl;
                lastg  = owner;
                owner  = -1;
                cnt    = 0;
            end else begin
                cnt++;
            end
        end
        cyc++;
    endtask

    initial begin
        int starts[$];
        model_reset();
        for (int s = 0; s < 2; s++) begin
            vpct[s] = 0; fixlen[s] = 0; v[s] = 1'b0; l[s] = 1'b0; new_pkt(s);
        end
        nxt[0] = 8'h10; nxt[1] = 8'h80; d[0] = 8'h10; d[1] = 8'h80;
        rpct = 100;
        #12;
        check_val("rst_tvalid", TVALID_out, 1'b0);
        check_val("rst_tlast",  TLAST_out, 1'b0);
        check_val("rst_data",   DATA_out, 8'h00);
        check_val("rst_rdy0",   TREADY_in_0, 1'b0);
        check_val("rst_rdy1",   TREADY_in_1, 1'b0);
        check_val("rst_grant",  grant, GNT_NONE);
        check_val("rst_trunc",  trunc, 1'b0);

        // Single source, 8-beat packets starting at 0x10.
        do_reset();
        fixlen[0] = 8; new_pkt(0); vpct[0] = 100; rpct = 100;
        repeat (20) step();
        check_val("single_first_cyc", ob_cyc.size() > 0 ? ob_cyc[0] : -1, 1);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("single_data%0d", i), ob_data.size() > i ? ob_data[i] : 8'hxx, 8'h10 + i);
            check_val($sformatf("single_last%0d", i), ob_last.size() > i ? ob_last[i] : 1'bx, (i == 7));
        end
        check_val("single_gnt", ob_gnt.size() > 0 ? ob_gnt[0] : 2'bxx, GNT_0);
        check_val("single_gap", ob_cyc.size() > 8 ? ob_cyc[8] - ob_cyc[7] : -1, 2);

        // Contention: both always valid, 8 and 16 beat packets.
        do_reset();
        fixlen[0] = 8; fixlen[1] = 16; new_pkt(0); new_pkt(1);
        vpct[0] = 100; vpct[1] = 100; rpct = 100;
        repeat (100) step();
        for (int i = 0; i < ob_data.size(); i++)
            if (i == 0 || ob_last[i-1]) starts.push_back(i);
        check_val("cont_npkts", starts.size() >= 5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (starts.size() > k + 1) begin
                check_val($sformatf("cont_gnt%0d", k), ob_gnt[starts[k]], (k % 2 == 0) ? GNT_0 : GNT_1);
                check_val($sformatf("cont_len%0d", k), starts[k+1] - starts[k], (k % 2 == 0) ? 8 : 16);
                check_val($sformatf("cont_gap%0d", k), ob_cyc[starts[k+1]] - ob_cyc[starts[k+1]-1], 2);
            end
        end

        // Watchdog: source 0 never ends its packet; source 1 waiting.
        do_reset();
        fixlen[0] = 1000; fixlen[1] = 4; new_pkt(0); new_pkt(1);
        vpct[0] = 100; rpct = 100;
        repeat (5) step();
        vpct[1] = 100;
        repeat (25) step();
        check_val("wd_last16", ob_last.size() > 16 ? ob_last[15] : 1'bx, 1'b1);
        check_val("wd_data16", ob_data.size() > 16 ? ob_data[15] : 8'hxx, 8'h1F);
        check_val("wd_trunc",  ob_cyc.size() > 16 ? t_log[ob_cyc[15] + 1] : 1'bx, 1'b1);
        check_val("wd_idle",   ob_cyc.size() > 16 ? g_log[ob_cyc[15] + 1] : 2'bxx, GNT_NONE);
        check_val("wd_next",   ob_gnt.size() > 16 ? ob_gnt[16] : 2'bxx, GNT_1);

        // Reset during beat 4 of a source 1 packet.
        do_reset();
        fixlen[1] = 8; new_pkt(1); vpct[1] = 100; rpct = 100;
        repeat (5) step();
        #1 ARESETn = 1'b0;
        #1;
        check_val("mrst_tvalid", TVALID_out, 1'b0);
        check_val("mrst_tlast",  TLAST_out, 1'b0);
        check_val("mrst_data",   DATA_out, 8'h00);
        check_val("mrst_rdy1",   TREADY_in_1, 1'b0);
        check_val("mrst_grant",  grant, GNT_NONE);
        #4 ARESETn = 1'b1;
        model_reset();
        vpct[0] = 100;
        repeat (2) step();
        check_val("mrst_regrant", grant, GNT_0);

        // Randomized traffic with gaps and back-pressure.
        do_reset();
        vpct[0] = 60; vpct[1] = 55; rpct = 70;
        repeat (4000) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
